// File: rtl/multi_counter_pkg.sv
// Shared types for the multi_counter block family: command opcodes and the dump FSM states.
package multi_counter_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_INC   = 2'd1,
    OP_INIT  = 2'd2,
    OP_QUERY = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_QRY   = 2'd1,
    DUMP_CLR   = 2'd2,
    DUMP_DRAIN = 2'd3
  } dump_state_t;

endpackage

// File: rtl/multi_counter_dump_fifo.sv
// Single-clock show-ahead FIFO; a pop frees the slot for a push in the same cycle.
module multi_counter_dump_fifo #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N+1);

  logic [W-1:0]  mem_r [N];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (count_r == CW'(N));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(N-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_do_push) mem_r[wr_ptr_r] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (w_do_push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (w_do_pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({w_do_push, w_do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/multi_counter_dump.sv
// Dump master for multi_counter: queries (and optionally clears) every counter in ID order
// and streams the results out, using credits so the status path never needs backpressure.
module multi_counter_dump
  import multi_counter_pkg::*;
#(
  parameter int unsigned CNTRS_N    = 256,
  parameter int unsigned CNTRS_W    = 32,
  parameter int unsigned CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_req,
  input  logic                  dump_clr,
  output logic                  dump_busy_r,
  output logic                  dump_done_r,
  output logic                  err_r,
  output logic                  cntr_pass,
  output logic [CNTRS_ID_W-1:0] cntr_id,
  output op_t                   cntr_op,
  output logic [CNTRS_W-1:0]    cntr_dat,
  input  logic                  status_pass_r,
  input  logic                  status_qry_r,
  input  logic [CNTRS_ID_W-1:0] status_id_r,
  input  logic [CNTRS_W-1:0]    status_dat_r,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [CNTRS_ID_W-1:0] out_id,
  output logic [CNTRS_W-1:0]    out_dat,
  output logic                  out_last
);

  localparam int unsigned CRD_W = $clog2(FIFO_DEPTH+1);
  localparam int unsigned PAY_W = CNTRS_ID_W + CNTRS_W;
  localparam logic [CNTRS_ID_W-1:0] LAST_ID = CNTRS_ID_W'(CNTRS_N-1);

  dump_state_t           state_r, w_state_nxt;
  logic                  clr_r, w_clr_nxt;
  logic [CNTRS_ID_W-1:0] issue_id_r, w_issue_id_nxt;
  logic [CNTRS_ID_W-1:0] exp_id_r;
  logic [CRD_W-1:0]      outstanding_r;

  logic                  w_pass_nxt, w_busy_nxt, w_done_nxt;
  op_t                   w_op_nxt;
  logic [CNTRS_ID_W-1:0] w_id_nxt;
  logic [CNTRS_W-1:0]    w_dat_nxt;

  logic                  w_start, w_cur_clr, w_credit, w_issue_q;
  logic [CNTRS_ID_W-1:0] w_cur_id;
  logic                  w_beat, w_bad, w_push, w_dec, w_pop;
  logic [CRD_W-1:0]      w_fifo_count;
  logic                  w_fifo_full, w_fifo_empty;
  logic [PAY_W-1:0]      w_fifo_dout;
  logic [CRD_W:0]        w_credit_sum;

  // The start cycle acts as the first QRY cycle so the first command lands with busy.
  assign w_start      = (state_r == DUMP_IDLE) && dump_req && !dump_done_r;
  assign w_cur_id     = w_start ? '0 : issue_id_r;
  assign w_cur_clr    = w_start ? dump_clr : clr_r;
  assign w_credit_sum = (CRD_W+1)'(outstanding_r) + (CRD_W+1)'(w_fifo_count);
  assign w_credit     = !w_fifo_full && (w_credit_sum < (CRD_W+1)'(FIFO_DEPTH));
  assign w_issue_q    = (w_start || (state_r == DUMP_QRY)) && w_credit;

  assign w_beat = status_pass_r && status_qry_r;
  assign w_bad  = w_beat && ((outstanding_r == '0) || (status_id_r != exp_id_r));
  assign w_push = w_beat && !w_bad;
  // Any returned query frees its credit, even a misordered one, so the dump cannot stall.
  assign w_dec  = w_beat && (outstanding_r != '0);
  assign w_pop  = out_vld && out_rdy;

  always_comb begin
    w_state_nxt    = state_r;
    w_issue_id_nxt = issue_id_r;
    w_clr_nxt      = clr_r;
    w_pass_nxt     = 1'b0;
    w_op_nxt       = OP_NOP;
    w_id_nxt       = '0;
    w_dat_nxt      = '0;
    w_busy_nxt     = dump_busy_r;
    w_done_nxt     = 1'b0;
    case (state_r)
      DUMP_IDLE: begin
        if (w_start) begin
          w_clr_nxt      = dump_clr;
          w_issue_id_nxt = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = DUMP_QRY;
        end
      end
      DUMP_CLR: begin
        w_pass_nxt = 1'b1;
        w_op_nxt   = OP_INIT;
        w_id_nxt   = issue_id_r;
        if (issue_id_r == LAST_ID) begin
          w_state_nxt = DUMP_DRAIN;
        end else begin
          w_issue_id_nxt = issue_id_r + CNTRS_ID_W'(1);
          w_state_nxt    = DUMP_QRY;
        end
      end
      DUMP_DRAIN: begin
        if (w_pop && out_last) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = DUMP_IDLE;
        end
      end
      default: w_state_nxt = state_r;
    endcase
    if (w_issue_q) begin
      w_pass_nxt = 1'b1;
      w_op_nxt   = OP_QUERY;
      w_id_nxt   = w_cur_id;
      if (w_cur_clr) begin
        w_state_nxt = DUMP_CLR;
      end else if (w_cur_id == LAST_ID) begin
        w_state_nxt = DUMP_DRAIN;
      end else begin
        w_issue_id_nxt = w_cur_id + CNTRS_ID_W'(1);
        w_state_nxt    = DUMP_QRY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= DUMP_IDLE;
      clr_r         <= 1'b0;
      issue_id_r    <= '0;
      exp_id_r      <= '0;
      outstanding_r <= '0;
      err_r         <= 1'b0;
      dump_busy_r   <= 1'b0;
      dump_done_r   <= 1'b0;
      cntr_pass     <= 1'b0;
      cntr_op       <= OP_NOP;
      cntr_id       <= '0;
      cntr_dat      <= '0;
    end else begin
      state_r     <= w_state_nxt;
      clr_r       <= w_clr_nxt;
      issue_id_r  <= w_issue_id_nxt;
      dump_busy_r <= w_busy_nxt;
      dump_done_r <= w_done_nxt;
      cntr_pass   <= w_pass_nxt;
      cntr_op     <= w_op_nxt;
      cntr_id     <= w_id_nxt;
      cntr_dat    <= w_dat_nxt;
      if (w_bad) err_r <= 1'b1;
      if (w_start)     exp_id_r <= '0;
      else if (w_push) exp_id_r <= exp_id_r + CNTRS_ID_W'(1);
      case ({w_issue_q, w_dec})
        2'b10:   outstanding_r <= outstanding_r + CRD_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CRD_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  multi_counter_dump_fifo #(
    .W (PAY_W),
    .N (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({status_id_r, status_dat_r}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign out_vld  = !w_fifo_empty;
  assign out_id   = w_fifo_dout[PAY_W-1:CNTRS_W];
  assign out_dat  = w_fifo_dout[CNTRS_W-1:0];
  assign out_last = out_vld && (out_id == LAST_ID);

endmodule

// File: tb/tb_multi_counter_dump.sv
// Bench for multi_counter_dump: behavioural multi_counter (4-cycle status latency) plus a
// scoreboard built from counter snapshots taken before each dump.
module tb_multi_counter_dump;
  import multi_counter_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned D  = 8;

  typedef struct packed { logic [IW-1:0] id; logic [W-1:0] dat; } ent_t;
  typedef struct { logic pass; logic qry; logic [IW-1:0] id; logic [W-1:0] dat; } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dump_req = 1'b0, dump_clr = 1'b0;
  logic          dump_busy_r, dump_done_r, err_r;
  logic          cntr_pass;
  logic [IW-1:0] cntr_id;
  op_t           cntr_op;
  logic [W-1:0]  cntr_dat;
  logic          status_pass_r = 1'b0, status_qry_r = 1'b0;
  logic [IW-1:0] status_id_r = '0;
  logic [W-1:0]  status_dat_r = '0;
  logic          out_vld, out_last;
  logic          out_rdy = 1'b0;
  logic [IW-1:0] out_id;
  logic [W-1:0]  out_dat;

  multi_counter_dump #(.CNTRS_N(N), .CNTRS_W(W), .CNTRS_ID_W(IW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req), .dump_clr(dump_clr),
    .dump_busy_r(dump_busy_r), .dump_done_r(dump_done_r), .err_r(err_r),
    .cntr_pass(cntr_pass), .cntr_id(cntr_id), .cntr_op(cntr_op), .cntr_dat(cntr_dat),
    .status_pass_r(status_pass_r), .status_qry_r(status_qry_r),
    .status_id_r(status_id_r), .status_dat_r(status_dat_r),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_dat(out_dat),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_err = 0;
  int   cyc = 0, nq = 0, ndone = 0, last_hs_cyc = -10;
  int   rdy_mode = 0;
  logic chk_alt = 1'b0, inj = 1'b0, arm_req_done = 1'b0, req_pend = 1'b0;
  op_t  last_op = OP_INIT;
  logic [W-1:0] cnt [N];
  logic [W-1:0] saved [N];
  ent_t exp_q [$];
  beat_t dl [5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counter model, downstream sink and scoreboard, all evaluated mid-cycle.
  initial begin
    beat_t nb;
    ent_t  e;
    for (int i = 0; i < 5; i++) dl[i] = '{default: '0};
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0:       out_rdy = 1'b0;
        1:       out_rdy = 1'b1;
        default: out_rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (dump_done_r) begin
        ndone++;
        chk("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        chk("busy_falls_with_done", 64'(dump_busy_r), 64'(0));
      end
      if (out_vld && out_rdy) begin
        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_id", 64'(out_id), 64'(e.id));
          chk("out_dat", 64'(out_dat), 64'(e.dat));
          chk("out_last", 64'(out_last), 64'(e.id == IW'(N-1)));
        end
        if (out_last) last_hs_cyc = cyc;
      end
      nb = '{default: '0};
      if (cntr_pass) begin
        nb.pass = 1'b1;
        nb.id   = cntr_id;
        if (cntr_op == OP_QUERY) begin
          nq++;
          nb.qry = 1'b1;
          nb.dat = cnt[cntr_id];
        end else if (cntr_op == OP_INIT) begin
          cnt[cntr_id] = cntr_dat;
        end
        if (chk_alt) begin
          chk("cmd_alternates", 64'(cntr_op), 64'((last_op == OP_QUERY) ? OP_INIT : OP_QUERY));
          last_op = cntr_op;
        end
      end
      for (int i = 4; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = nb;
      if (inj) begin
        status_pass_r = 1'b1; status_qry_r = 1'b1; status_id_r = IW'(2); status_dat_r = 32'hdead;
        inj = 1'b0;
      end else begin
        status_pass_r = dl[4].pass; status_qry_r = dl[4].qry;
        status_id_r   = dl[4].id;   status_dat_r = dl[4].dat;
      end
      if (arm_req_done && dump_done_r) begin
        dump_req = 1'b1; arm_req_done = 1'b0; req_pend = 1'b1;
      end else if (req_pend) begin
        dump_req = 1'b0; req_pend = 1'b0;
        chk("req_at_done_ignored", 64'(dump_busy_r), 64'(0));
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      cnt[i]   = $urandom;
      saved[i] = cnt[i];
    end
  endtask

  task automatic start_dump(input logic clr, input int mode);
    for (int i = 0; i < N; i++) exp_q.push_back('{id: IW'(i), dat: cnt[i]});
    rdy_mode = mode;
    chk_alt  = clr;
    last_op  = OP_INIT;
    @(negedge clk);
    dump_clr = clr; dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0; dump_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = ndone;
    int i  = 0;
    while (ndone == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(ndone != d0), 64'(1));
    @(negedge clk);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    chk_alt = 1'b0;
  endtask

  initial begin
    int nq0, nd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(dump_busy_r), 64'(0));
    chk("rst_done", 64'(dump_done_r), 64'(0));
    chk("rst_err", 64'(err_r), 64'(0));
    chk("rst_vld", 64'(out_vld), 64'(0));
    chk("rst_pass", 64'(cntr_pass), 64'(0));
    chk("rst_op", 64'(cntr_op), 64'(OP_NOP));
    chk("rst_id", 64'(cntr_id), 64'(0));
    chk("rst_dat", 64'(cntr_dat), 64'(0));

    // plain dump, always ready; first command must land with busy
    preload();
    nq0 = nq;
    start_dump(1'b0, 1);
    chk("first_busy", 64'(dump_busy_r), 64'(1));
    chk("first_pass", 64'(cntr_pass), 64'(1));
    chk("first_op", 64'(cntr_op), 64'(OP_QUERY));
    chk("first_id", 64'(cntr_id), 64'(0));
    wait_done("dump_plain", 400);
    chk("plain_nq", 64'(nq - nq0), 64'(N));
    for (int i = 0; i < N; i++) chk("cnt_unchanged", 64'(cnt[i]), 64'(saved[i]));

    // query-and-clear, then a second dump must read zeros
    preload();
    start_dump(1'b1, 2);
    wait_done("dump_clr", 600);
    for (int i = 0; i < N; i++) chk("cnt_cleared", 64'(cnt[i]), 64'(0));
    start_dump(1'b0, 2);
    wait_done("dump_zero", 600);

    // no downstream ready: credits cap issue at FIFO_DEPTH
    preload();
    nq0 = nq;
    start_dump(1'b0, 0);
    repeat (40) @(negedge clk);
    chk("stall_nq", 64'(nq - nq0), 64'(D));
    chk("stall_pass", 64'(cntr_pass), 64'(0));
    chk("stall_vld", 64'(out_vld), 64'(1));
    rdy_mode = 2;
    wait_done("dump_stall", 600);
    chk("stall_total_nq", 64'(nq - nq0), 64'(N));

    // spurious status beat while idle
    chk("err_clean", 64'(err_r), 64'(0));
    @(negedge clk);
    inj = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_err", 64'(err_r), 64'(1));
    chk("spurious_no_push", 64'(out_vld), 64'(0));
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err_r), 64'(1));

    // dump_req while busy and on the done cycle are ignored
    preload();
    nd0 = ndone;
    nq0 = nq;
    start_dump(1'b0, 2);
    arm_req_done = 1'b1;
    repeat (5) @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    wait_done("dump_busyreq", 600);
    repeat (30) @(negedge clk);
    chk("single_done", 64'(ndone - nd0), 64'(1));
    chk("busyreq_nq", 64'(nq - nq0), 64'(N));
    chk("busyreq_idle", 64'(dump_busy_r), 64'(0));

    // reset in the middle of a dump, then a fresh dump
    preload();
    start_dump(1'b0, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(dump_busy_r), 64'(0));
    chk("midrst_vld", 64'(out_vld), 64'(0));
    chk("midrst_pass", 64'(cntr_pass), 64'(0));
    chk("midrst_err", 64'(err_r), 64'(0));
    repeat (10) @(negedge clk);
    exp_q.delete();
    chk("stale_err", 64'(err_r), 64'(1));
    chk("stale_no_push", 64'(out_vld), 64'(0));
    preload();
    start_dump(1'b0, 2);
    wait_done("dump_after_rst", 600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
